// File: rtl/pulse_gen_pkg.sv
// Shared types and default widths for the pulse train generator.
package pulse_gen_pkg;

  // Train sequencer states; IDLE must stay the all-zero encoding so reset lands there.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pulseStateT;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_N_W   = 8;

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down counter with a zero flag; saturates at zero instead of wrapping.
module cycle_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         enable,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (enable && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: hi cycles high, lo cycles low, repeated n times,
// with per-edge strobes and busy/done/aborted status. All outputs registered.
//
// Handshake: start is a one-cycle request that is accepted only when the
// sequencer is IDLE and abort is low in the same cycle; while busy, start is
// dropped (no queuing). abort is honoured only while busy and ends the train
// on the next cycle with a one-cycle aborted pulse.
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int N_W   = DEF_N_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] highCycles,
  input  logic [CNT_W-1:0] lowCycles,
  input  logic [N_W-1:0]   pulseCount,
  output logic             signalOut,
  output logic             risingEdge,
  output logic             fallingEdge,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  // Current sequencer state; kept as a named signal so checkers can bind to it.
  pulseStateT state, stateNext;

  // Durations are stored as (duration - 1) with zero clamped to one cycle,
  // which is exactly the reload value the down counter needs.
  logic [CNT_W-1:0] hiM1Reg, loM1Reg, hiM1Next, loM1Next;
  logic [CNT_W-1:0] hiM1In, loM1In;
  logic [N_W-1:0]   remCnt, remNext;

  logic             cntLoad, cntEnable, cntZero;
  logic [CNT_W-1:0] cntValue;

  logic sigNext, riseNext, fallNext, busyNext, doneNext, abortedNext;

  assign hiM1In = (highCycles == '0) ? '0 : highCycles - CNT_W'(1);
  assign loM1In = (lowCycles  == '0) ? '0 : lowCycles  - CNT_W'(1);

  cycle_down_counter #(.W(CNT_W)) u_durCnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cntLoad),
    .value  (cntValue),
    .enable (cntEnable),
    .zero   (cntZero)
  );

  // Next-state, counter control and next registered outputs.
  always_comb begin
    stateNext   = state;
    hiM1Next    = hiM1Reg;
    loM1Next    = loM1Reg;
    remNext     = remCnt;
    cntLoad     = 1'b0;
    cntValue    = '0;
    cntEnable   = 1'b0;
    sigNext     = 1'b0;
    riseNext    = 1'b0;
    fallNext    = 1'b0;
    busyNext    = 1'b0;
    doneNext    = 1'b0;
    abortedNext = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          hiM1Next = hiM1In;
          loM1Next = loM1In;
          if (pulseCount == '0) begin
            doneNext = 1'b1;
          end else begin
            stateNext = HIGH;
            sigNext   = 1'b1;
            riseNext  = 1'b1;
            busyNext  = 1'b1;
            cntLoad   = 1'b1;
            cntValue  = hiM1In;
            remNext   = pulseCount;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          // signalOut is always 1 in HIGH, so stopping here is a falling edge.
          stateNext   = IDLE;
          fallNext    = 1'b1;
          abortedNext = 1'b1;
          cntLoad     = 1'b1;
          remNext     = '0;
        end else if (cntZero) begin
          stateNext = LOW;
          fallNext  = 1'b1;
          busyNext  = 1'b1;
          cntLoad   = 1'b1;
          cntValue  = loM1Reg;
        end else begin
          sigNext   = 1'b1;
          busyNext  = 1'b1;
          cntEnable = 1'b1;
        end
      end
      LOW: begin
        if (abort) begin
          stateNext   = IDLE;
          abortedNext = 1'b1;
          cntLoad     = 1'b1;
          remNext     = '0;
        end else if (cntZero) begin
          if (remCnt > N_W'(1)) begin
            stateNext = HIGH;
            sigNext   = 1'b1;
            riseNext  = 1'b1;
            busyNext  = 1'b1;
            cntLoad   = 1'b1;
            cntValue  = hiM1Reg;
            remNext   = remCnt - N_W'(1);
          end else begin
            stateNext = IDLE;
            doneNext  = 1'b1;
            remNext   = '0;
          end
        end else begin
          busyNext  = 1'b1;
          cntEnable = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State, latched parameters, remaining-pulse count and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hiM1Reg     <= '0;
      loM1Reg     <= '0;
      remCnt      <= '0;
      signalOut   <= 1'b0;
      risingEdge  <= 1'b0;
      fallingEdge <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      state       <= stateNext;
      hiM1Reg     <= hiM1Next;
      loM1Reg     <= loM1Next;
      remCnt      <= remNext;
      signalOut   <= sigNext;
      risingEdge  <= riseNext;
      fallingEdge <= fallNext;
      busy        <= busyNext;
      done        <= doneNext;
      aborted     <= abortedNext;
    end
  end

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
Generates timed edges on a single output line. It is the transmit-side counterpart to the input edge detector: it produces a programmable train of pulses with exact high and low durations, plus per-edge strobes. A one-cycle start request launches the train; busy, done and aborted report status to the controlling logic, for example the LED or test-pin drivers on the board top level.

Parameters:
CNT_W, 16, width of the highCycles/lowCycles duration fields and of the internal cycle counter
N_W, 8, width of the pulseCount field and of the remaining-pulse counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; accepted only in IDLE
abort  input  1  synchronous stop request; acts only while busy
highCycles  input  CNT_W  high duration per pulse, in clk cycles; sampled on accept
lowCycles  input  CNT_W  low duration per pulse, in clk cycles; sampled on accept
pulseCount  input  N_W  number of pulses; sampled on accept
signalOut  output  1  generated waveform, registered
risingEdge  output  1  one-cycle strobe, high in the first cycle signalOut is 1
fallingEdge  output  1  one-cycle strobe, high in the first cycle signalOut returns to 0
busy  output  1  high while a train is in progress
done  output  1  one-cycle pulse when a train completes normally
aborted  output  1  one-cycle pulse when a train is stopped by abort

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, all counters 0, and every output is 0 immediately without waiting for clk.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States:
  - IDLE: no train in progress.
  - HIGH: signalOut=1, counting the high duration.
  - LOW: signalOut=0, counting the low duration.
- Accept: in IDLE with start=1 and abort=0, latch hi=max(highCycles,1), lo=max(lowCycles,1) and n=pulseCount. The accept cycle is T.
  - n=0: done=1 at T+1; busy, signalOut and the strobes stay 0; state stays IDLE.
  - n>0, at T+1: state=HIGH, signalOut=1, risingEdge=1, busy=1, cnt=hi-1, remaining=n.
- HIGH, each cycle:
  - cnt>0: decrement cnt.
  - cnt=0: next cycle state=LOW, signalOut=0, fallingEdge=1, cnt=lo-1.
- LOW, each cycle:
  - cnt>0: decrement cnt.
  - cnt=0 and remaining>1: next cycle state=HIGH, signalOut=1, risingEdge=1, cnt=hi-1, remaining-1.
  - cnt=0 and remaining=1: next cycle state=IDLE, busy=0, done=1.
- Resulting timing: each pulse is high exactly hi cycles and low exactly lo cycles, including a trailing low period on the last pulse.
  - signalOut high during T+1 .. T+hi.
  - busy high from T+1 through T+n*(hi+lo).
  - done asserted at T+n*(hi+lo)+1.
- start while busy is ignored; no queuing.
- start during the done cycle is accepted, because the state is IDLE in that cycle.
- abort while busy: next cycle state=IDLE, signalOut=0, busy=0, aborted=1, done=0.
  - fallingEdge=1 only if signalOut was 1.
  - abort in IDLE has no effect.
  - abort together with start in IDLE: abort wins, start is ignored and aborted stays 0.
- Width rules:
  - Durations up to 2^CNT_W-1 cycles; counters never wrap.
  - highCycles=0 or lowCycles=0 is treated as 1.
  - pulseCount up to 2^N_W-1.
- risingEdge and fallingEdge are never high in the same cycle. done and aborted are never high in the same cycle.
- Reset deasserted mid-train: the block restarts from IDLE; no resume.

Decomposition:
- Shared package pulse_gen_pkg:
  - state enum: IDLE, HIGH, LOW (2-bit encoding)
  - default CNT_W and N_W constants
- One sub-module, cycle_down_counter (parameter W): async active-low reset, load/value/enable, and a zero flag. One instance provides the duration counter.
- The remaining-pulse counter and the FSM stay in the top module.

Test Plan:
- Nominal train, hi=3, lo=2, n=2, start at cycle 0 -> signalOut=1 in cycles 1-3 and 6-8, 0 in 4-5 and 9-10; risingEdge at 1 and 6; fallingEdge at 4 and 9; busy during 1-10; done only at 11.
- Zero-duration clamp, hi=0, lo=0, n=3 -> signalOut alternates 1,0 over cycles 1-6; done at 7; strobes on every transition.
- Empty train, n=0 -> done at cycle 1; busy, signalOut and strobes stay 0 throughout.
- Abort and ignored start, hi=5, lo=5, n=4:
  - abort at cycle 2 -> at cycle 3 signalOut=0, fallingEdge=1, aborted=1, busy=0; done never asserts.
  - start at cycle 1 (while busy) -> ignored.
- Restart on done: start asserted in the done cycle of a hi=1, lo=1, n=1 train -> new train begins with risingEdge one cycle later. Separately, abort and start together in IDLE -> no train starts and aborted stays 0.
- Asynchronous reset: rst_n driven low mid-HIGH, between clk edges -> signalOut, busy and the strobes go 0 immediately. After rst_n releases, start with hi=2, lo=1, n=1 runs normally and done arrives 4 cycles after accept.
